// File: rtl/frame_renderer_pkg.sv
// Shared constants and state encoding for the frame renderer and its rectangle scanner.
package frame_renderer_pkg;

    localparam logic [2:0] BIRD_COLOUR       = 3'b010;
    localparam logic [2:0] WALL_COLOUR       = 3'b100;
    localparam logic [2:0] BACKGROUND_COLOUR = 3'b111;

    localparam logic [7:0] BIRD_Y_START = 8'd60;
    localparam logic [7:0] WALL_X_START = 8'd100;

    localparam int unsigned SCREEN_W_DEF = 160;
    localparam int unsigned SCREEN_H_DEF = 120;

    // One bit wider than the screen coordinates so origin+size never wraps.
    localparam int unsigned COORD_W = 9;

    typedef enum logic [2:0] {
        StIdle,
        StClrBird,
        StClrWall,
        StDrwWall,
        StDrwBird,
        StDone
    } render_state_e;

endpackage

// File: rtl/frame_renderer_rect_scanner.sv
// Raster-order walker over one rectangle; reloaded by the renderer FSM for each pass.
module rect_scanner
    import frame_renderer_pkg::*;
#(
    parameter int unsigned SCREEN_W = SCREEN_W_DEF,
    parameter int unsigned SCREEN_H = SCREEN_H_DEF
) (
    input  logic               clk_i,
    input  logic               resetn_i,
    input  logic               load_i,
    input  logic [COORD_W-1:0] origin_x_i,
    input  logic [COORD_W-1:0] origin_y_i,
    input  logic [COORD_W-1:0] width_i,
    input  logic [COORD_W-1:0] height_i,
    input  logic               advance_i,
    output logic [7:0]         x_o,
    output logic [COORD_W-1:0] y_o,
    output logic               last_o,
    output logic               in_bounds_o
);

    logic [COORD_W-1:0] x_q, x_d, y_q, y_d;
    logic [COORD_W-1:0] x0_q, x0_d, x_end_q, x_end_d, y_end_q, y_end_d;

    always_comb begin
        x_d     = x_q;
        y_d     = y_q;
        x0_d    = x0_q;
        x_end_d = x_end_q;
        y_end_d = y_end_q;
        if (load_i) begin
            x_d     = origin_x_i;
            y_d     = origin_y_i;
            x0_d    = origin_x_i;
            x_end_d = origin_x_i + width_i - COORD_W'(1);
            y_end_d = origin_y_i + height_i - COORD_W'(1);
        end else if (advance_i) begin
            if (x_q == x_end_q) begin
                x_d = x0_q;
                y_d = y_q + COORD_W'(1);
            end else begin
                x_d = x_q + COORD_W'(1);
            end
        end
    end

    always_ff @(posedge clk_i or negedge resetn_i) begin
        if (!resetn_i) begin
            x_q     <= '0;
            y_q     <= '0;
            x0_q    <= '0;
            x_end_q <= '0;
            y_end_q <= '0;
        end else begin
            x_q     <= x_d;
            y_q     <= y_d;
            x0_q    <= x0_d;
            x_end_q <= x_end_d;
            y_end_q <= y_end_d;
        end
    end

    assign x_o         = x_q[7:0];
    assign y_o         = y_q;
    assign last_o      = (x_q == x_end_q) && (y_q == y_end_q);
    assign in_bounds_o = (x_q < COORD_W'(SCREEN_W)) && (y_q < COORD_W'(SCREEN_H));

endmodule

// File: rtl/frame_renderer.sv
// Per-tick renderer: erases previous bird and wall, draws the wall with its gap, then the bird.
module frame_renderer
    import frame_renderer_pkg::*;
#(
    parameter int unsigned SCREEN_W   = SCREEN_W_DEF,
    parameter int unsigned SCREEN_H   = SCREEN_H_DEF,
    parameter int unsigned BIRD_X     = 20,
    parameter int unsigned BIRD_SIZE  = 4,
    parameter int unsigned WALL_WIDTH = 10,
    parameter int unsigned GAP_H      = 40
) (
    input  logic       clk_i,
    input  logic       resetn_i,
    input  logic       start_i,
    input  logic [7:0] bird_y_i,
    input  logic [7:0] wall_x_i,
    input  logic [7:0] gap_y_i,
    input  logic       pix_ready_i,
    output logic [7:0] x_out_o,
    output logic [6:0] y_out_o,
    output logic [2:0] colour_out_o,
    output logic       plot_o,
    output logic       busy_o,
    output logic       done_o
);

    render_state_e state_q, state_d;
    logic [7:0] cur_bird_y_q, cur_wall_x_q, cur_gap_y_q;
    logic [7:0] prev_bird_y_q, prev_wall_x_q;

    logic               ld;
    logic               adv;
    logic [COORD_W-1:0] ld_x, ld_y, ld_w, ld_h;
    logic [7:0]         scan_x;
    logic [COORD_W-1:0] scan_y;
    logic               scan_last, scan_in_bounds;
    logic               scanning, in_gap, emit, step;
    logic [2:0]         colour;

    rect_scanner #(
        .SCREEN_W (SCREEN_W),
        .SCREEN_H (SCREEN_H)
    ) u_scanner (
        .clk_i       (clk_i),
        .resetn_i    (resetn_i),
        .load_i      (ld),
        .origin_x_i  (ld_x),
        .origin_y_i  (ld_y),
        .width_i     (ld_w),
        .height_i    (ld_h),
        .advance_i   (adv),
        .x_o         (scan_x),
        .y_o         (scan_y),
        .last_o      (scan_last),
        .in_bounds_o (scan_in_bounds)
    );

    assign scanning = state_q inside {StClrBird, StClrWall, StDrwWall, StDrwBird};
    assign in_gap   = (state_q == StDrwWall)
                   && (scan_y >= {1'b0, cur_gap_y_q})
                   && (scan_y < ({1'b0, cur_gap_y_q} + COORD_W'(GAP_H)));
    assign emit     = scanning && scan_in_bounds && !in_gap;
    // Hidden positions (clipped or gap) cost exactly one cycle and need no handshake.
    assign step     = scanning && (!emit || pix_ready_i);

    always_comb begin
        state_d = state_q;
        ld      = 1'b0;
        adv     = 1'b0;
        ld_x    = '0;
        ld_y    = '0;
        ld_w    = '0;
        ld_h    = '0;
        unique case (state_q)
            StIdle: begin
                if (start_i) begin
                    state_d = StClrBird;
                    ld      = 1'b1;
                    ld_x    = COORD_W'(BIRD_X);
                    ld_y    = {1'b0, prev_bird_y_q};
                    ld_w    = COORD_W'(BIRD_SIZE);
                    ld_h    = COORD_W'(BIRD_SIZE);
                end
            end
            StClrBird: begin
                if (step && scan_last) begin
                    state_d = StClrWall;
                    ld      = 1'b1;
                    ld_x    = {1'b0, prev_wall_x_q};
                    ld_w    = COORD_W'(WALL_WIDTH);
                    ld_h    = COORD_W'(SCREEN_H);
                end else begin
                    adv = step;
                end
            end
            StClrWall: begin
                if (step && scan_last) begin
                    state_d = StDrwWall;
                    ld      = 1'b1;
                    ld_x    = {1'b0, cur_wall_x_q};
                    ld_w    = COORD_W'(WALL_WIDTH);
                    ld_h    = COORD_W'(SCREEN_H);
                end else begin
                    adv = step;
                end
            end
            StDrwWall: begin
                if (step && scan_last) begin
                    state_d = StDrwBird;
                    ld      = 1'b1;
                    ld_x    = COORD_W'(BIRD_X);
                    ld_y    = {1'b0, cur_bird_y_q};
                    ld_w    = COORD_W'(BIRD_SIZE);
                    ld_h    = COORD_W'(BIRD_SIZE);
                end else begin
                    adv = step;
                end
            end
            StDrwBird: begin
                if (step && scan_last) begin
                    state_d = StDone;
                end else begin
                    adv = step;
                end
            end
            StDone:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        colour = 3'b000;
        unique case (state_q)
            StClrBird, StClrWall: colour = BACKGROUND_COLOUR;
            StDrwWall:            colour = WALL_COLOUR;
            StDrwBird:            colour = BIRD_COLOUR;
            default:              colour = 3'b000;
        endcase
    end

    always_ff @(posedge clk_i or negedge resetn_i) begin
        if (!resetn_i) begin
            state_q       <= StIdle;
            cur_bird_y_q  <= '0;
            cur_wall_x_q  <= '0;
            cur_gap_y_q   <= '0;
            prev_bird_y_q <= BIRD_Y_START;
            prev_wall_x_q <= WALL_X_START;
        end else begin
            state_q <= state_d;
            if (state_q == StIdle && start_i) begin
                cur_bird_y_q <= bird_y_i;
                cur_wall_x_q <= wall_x_i;
                cur_gap_y_q  <= gap_y_i;
            end
            if (state_q == StDone) begin
                prev_bird_y_q <= cur_bird_y_q;
                prev_wall_x_q <= cur_wall_x_q;
            end
        end
    end

    assign plot_o       = emit;
    assign x_out_o      = emit ? scan_x : '0;
    assign y_out_o      = emit ? scan_y[6:0] : '0;
    assign colour_out_o = emit ? colour : '0;
    assign busy_o       = (state_q != StIdle);
    assign done_o       = (state_q == StDone);

endmodule

// File: tb/tb_frame_renderer.sv
// Self-checking bench: drives frames and compares the accepted pixel stream with a rectangle model.
module tb_frame_renderer;

    typedef struct packed {
        logic [7:0] x;
        logic [6:0] y;
        logic [2:0] c;
    } pix_t;

    logic       clk = 1'b0;
    logic       resetn = 1'b1;
    logic       start = 1'b0;
    logic       pix_ready = 1'b1;
    logic [7:0] bird_y = '0, wall_x = '0, gap_y = '0;
    logic [7:0] x_out;
    logic [6:0] y_out;
    logic [2:0] colour_out;
    logic       plot, busy, done;

    int n_checks = 0;
    int n_fail = 0;
    pix_t obs[$];
    pix_t exp_q[$];
    int m_prev_by = 60;
    int m_prev_wx = 100;
    int f_cycles, f_dones, f_stalls, f_hold_viol, f_busy_viol, f_max_x;

    frame_renderer dut (
        .clk_i        (clk),
        .resetn_i     (resetn),
        .start_i      (start),
        .bird_y_i     (bird_y),
        .wall_x_i     (wall_x),
        .gap_y_i      (gap_y),
        .pix_ready_i  (pix_ready),
        .x_out_o      (x_out),
        .y_out_o      (y_out),
        .colour_out_o (colour_out),
        .plot_o       (plot),
        .busy_o       (busy),
        .done_o       (done)
    );

    always #5 clk = ~clk;

    function automatic void push_rect(int x0, int y0, int w, int h, logic [2:0] c, int gy, bit gap);
        for (int y = y0; y < y0 + h; y++) begin
            for (int x = x0; x < x0 + w; x++) begin
                if (x < 160 && y < 120 && !(gap && y >= gy && y < gy + 40))
                    exp_q.push_back(pix_t'{8'(x), 7'(y), c});
            end
        end
    endfunction

    // Expected accepted pixels for one frame; the model's previous positions then advance.
    function automatic void model_frame(int by, int wx, int gy);
        exp_q.delete();
        push_rect(20, m_prev_by, 4, 4, 3'b111, 0, 1'b0);
        push_rect(m_prev_wx, 0, 10, 120, 3'b111, 0, 1'b0);
        push_rect(wx, 0, 10, 120, 3'b100, gy, 1'b1);
        push_rect(20, by, 4, 4, 3'b010, 0, 1'b0);
        m_prev_by = by;
        m_prev_wx = wx;
    endfunction

    function automatic int first_diff();
        for (int i = 0; i < obs.size() && i < exp_q.size(); i++)
            if (obs[i] !== exp_q[i]) return i;
        if (obs.size() != exp_q.size())
            return (obs.size() < exp_q.size()) ? obs.size() : exp_q.size();
        return -1;
    endfunction

    task automatic run_frame(input logic [7:0] by, input logic [7:0] wx, input logic [7:0] gy,
                             input int stall_pct, input bit disturb, input int abort_at);
        bit   held;
        pix_t held_p;
        held = 1'b0;
        held_p = '0;
        obs.delete();
        f_cycles = 0; f_dones = 0; f_stalls = 0; f_hold_viol = 0; f_busy_viol = 0; f_max_x = 0;
        @(negedge clk);
        bird_y = by; wall_x = wx; gap_y = gy; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        while (f_cycles < 20000) begin
            f_cycles++;
            if (disturb && f_cycles == 5) begin
                bird_y = 8'($urandom); wall_x = 8'($urandom); gap_y = 8'($urandom);
            end
            start = disturb && (f_cycles == 10 || f_cycles == 2000);
            pix_ready = (stall_pct == 0) || ($urandom_range(0, 99) >= stall_pct);
            #1;
            if (held && !(plot && pix_t'{x_out, y_out, colour_out} == held_p)) f_hold_viol++;
            if (!busy) f_busy_viol++;
            held = 1'b0;
            if (plot) begin
                if (int'(x_out) > f_max_x) f_max_x = int'(x_out);
                if (pix_ready) obs.push_back(pix_t'{x_out, y_out, colour_out});
                else begin
                    f_stalls++;
                    held = 1'b1;
                    held_p = pix_t'{x_out, y_out, colour_out};
                end
            end
            if (done) begin
                f_dones++;
                break;
            end
            if (abort_at != 0 && f_cycles == abort_at) break;
            @(negedge clk);
        end
        start = 1'b0;
        pix_ready = 1'b1;
    endtask

    task automatic test_reset();
        #2 resetn = 1'b0;
        #1;
        n_checks++; if (plot !== 1'b0) begin n_fail++; $display("FAIL reset_plot got %b want 0", plot); end
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got %b want 0", busy); end
        n_checks++; if (done !== 1'b0) begin n_fail++; $display("FAIL reset_done got %b want 0", done); end
        n_checks++; if (x_out !== 8'd0) begin n_fail++; $display("FAIL reset_x got %0d want 0", x_out); end
        n_checks++; if (y_out !== 7'd0) begin n_fail++; $display("FAIL reset_y got %0d want 0", y_out); end
        n_checks++;
        if (colour_out !== 3'd0) begin n_fail++; $display("FAIL reset_colour got %b want 0", colour_out); end
        repeat (3) @(negedge clk);
        resetn = 1'b1;
        m_prev_by = 60;
        m_prev_wx = 100;
    endtask

    task automatic test_first_frame();
        int n_bg, n_wall, n_bird, n_in_gap, d;
        n_bg = 0; n_wall = 0; n_bird = 0; n_in_gap = 0;
        model_frame(60, 100, 40);
        run_frame(8'd60, 8'd100, 8'd40, 0, 1'b0, 0);
        foreach (obs[i]) begin
            if (obs[i].c == 3'b111) n_bg++;
            if (obs[i].c == 3'b100) n_wall++;
            if (obs[i].c == 3'b010) n_bird++;
            if (obs[i].c == 3'b100 && obs[i].y >= 40 && obs[i].y < 80) n_in_gap++;
        end
        d = first_diff();
        n_checks++;
        if (d !== -1) begin
            n_fail++;
            $display("FAIL first_stream diverges at %0d got %0d pixels want %0d", d, obs.size(), exp_q.size());
        end
        n_checks++; if (n_bg !== 1216) begin n_fail++; $display("FAIL first_bg got %0d want 1216", n_bg); end
        n_checks++; if (n_wall !== 800) begin n_fail++; $display("FAIL first_wall got %0d want 800", n_wall); end
        n_checks++; if (n_bird !== 16) begin n_fail++; $display("FAIL first_bird got %0d want 16", n_bird); end
        n_checks++; if (n_in_gap !== 0) begin n_fail++; $display("FAIL first_gap got %0d want 0", n_in_gap); end
        n_checks++; if (f_cycles !== 2433) begin n_fail++; $display("FAIL first_latency got %0d want 2433", f_cycles); end
        n_checks++; if (f_dones !== 1) begin n_fail++; $display("FAIL first_done got %0d want 1", f_dones); end
        n_checks++; if (f_busy_viol !== 0) begin n_fail++; $display("FAIL first_busy got %0d want 0", f_busy_viol); end
        @(negedge clk);
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL first_idle_busy got %b want 0", busy); end
        n_checks++; if (done !== 1'b0) begin n_fail++; $display("FAIL first_done_pulse got %b want 0", done); end
    endtask

    task automatic test_prev_update();
        int d;
        logic [7:0] gy;
        gy = 8'($urandom_range(0, 80));
        model_frame(50, 96, int'(gy));
        run_frame(8'd50, 8'd96, gy, 0, 1'b0, 0);
        d = first_diff();
        n_checks++;
        if (d !== -1) begin
            n_fail++;
            $display("FAIL prev_stream diverges at %0d got %0d pixels want %0d", d, obs.size(), exp_q.size());
        end
        n_checks++;
        if (obs.size() < 17 || obs[0] !== pix_t'{8'd20, 7'd60, 3'b111} || obs[16] !== pix_t'{8'd100, 7'd0, 3'b111}) begin
            n_fail++;
            $display("FAIL prev_origins got %h/%h want %h/%h", obs.size() > 0 ? obs[0] : '0,
                     obs.size() > 16 ? obs[16] : '0, pix_t'{8'd20, 7'd60, 3'b111}, pix_t'{8'd100, 7'd0, 3'b111});
        end
    endtask

    task automatic test_clip();
        int d, n_wall, n_bird;
        n_wall = 0; n_bird = 0;
        model_frame(118, 155, 30);
        run_frame(8'd118, 8'd155, 8'd30, 0, 1'b0, 0);
        foreach (obs[i]) begin
            if (obs[i].c == 3'b100) n_wall++;
            if (obs[i].c == 3'b010) n_bird++;
        end
        d = first_diff();
        n_checks++;
        if (d !== -1) begin
            n_fail++;
            $display("FAIL clip_stream diverges at %0d got %0d pixels want %0d", d, obs.size(), exp_q.size());
        end
        n_checks++; if (n_wall !== 400) begin n_fail++; $display("FAIL clip_wall got %0d want 400", n_wall); end
        n_checks++; if (n_bird !== 8) begin n_fail++; $display("FAIL clip_bird got %0d want 8", n_bird); end
        n_checks++; if (f_max_x >= 160) begin n_fail++; $display("FAIL clip_max_x got %0d want <160", f_max_x); end
        n_checks++; if (f_cycles !== 2433) begin n_fail++; $display("FAIL clip_latency got %0d want 2433", f_cycles); end
    endtask

    task automatic test_stall();
        int d, n_bird;
        logic [7:0] by, wx, gy;
        for (int k = 0; k < 3; k++) begin
            by = 8'($urandom_range(0, 125)); wx = 8'($urandom); gy = 8'($urandom_range(0, 100));
            model_frame(int'(by), int'(wx), int'(gy));
            run_frame(by, wx, gy, 40, 1'b0, 0);
            n_bird = 0;
            foreach (obs[i]) if (obs[i].c == 3'b010) n_bird++;
            d = first_diff();
            n_checks++;
            if (d !== -1) begin
                n_fail++;
                $display("FAIL stall_stream[%0d] diverges at %0d got %0d pixels want %0d", k, d, obs.size(), exp_q.size());
            end
            n_checks++;
            if (f_hold_viol !== 0) begin n_fail++; $display("FAIL stall_hold[%0d] got %0d want 0", k, f_hold_viol); end
            n_checks++;
            if (f_cycles !== 2433 + f_stalls) begin
                n_fail++;
                $display("FAIL stall_latency[%0d] got %0d want %0d", k, f_cycles, 2433 + f_stalls);
            end
            if (by <= 116) begin
                n_checks++;
                if (n_bird !== 16) begin n_fail++; $display("FAIL stall_bird[%0d] got %0d want 16", k, n_bird); end
            end
        end
    endtask

    task automatic test_busy_ignore();
        int d, extra;
        model_frame(33, 70, 10);
        run_frame(8'd33, 8'd70, 8'd10, 0, 1'b1, 0);
        d = first_diff();
        n_checks++;
        if (d !== -1) begin
            n_fail++;
            $display("FAIL busy_stream diverges at %0d got %0d pixels want %0d", d, obs.size(), exp_q.size());
        end
        n_checks++; if (f_dones !== 1) begin n_fail++; $display("FAIL busy_done got %0d want 1", f_dones); end
        extra = 0;
        repeat (3000) begin
            @(negedge clk);
            if (plot || done || busy) extra++;
        end
        n_checks++; if (extra !== 0) begin n_fail++; $display("FAIL busy_tail got %0d want 0", extra); end
    endtask

    task automatic test_random();
        int d;
        logic [7:0] by, wx, gy;
        for (int k = 0; k < 3; k++) begin
            by = 8'($urandom); gy = 8'($urandom);
            wx = (k == 0) ? 8'd250 : 8'($urandom);
            model_frame(int'(by), int'(wx), int'(gy));
            run_frame(by, wx, gy, 0, 1'b0, 0);
            d = first_diff();
            n_checks++;
            if (d !== -1) begin
                n_fail++;
                $display("FAIL rand_stream[%0d] diverges at %0d got %0d pixels want %0d", k, d, obs.size(), exp_q.size());
            end
            n_checks++; if (f_dones !== 1) begin n_fail++; $display("FAIL rand_done[%0d] got %0d want 1", k, f_dones); end
        end
    endtask

    task automatic test_reset_mid();
        int d;
        run_frame(8'd10, 8'd20, 8'd5, 0, 1'b0, 300);
        #2 resetn = 1'b0;
        #1;
        n_checks++; if (plot !== 1'b0) begin n_fail++; $display("FAIL midreset_plot got %b want 0", plot); end
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL midreset_busy got %b want 0", busy); end
        @(negedge clk);
        resetn = 1'b1;
        m_prev_by = 60;
        m_prev_wx = 100;
        model_frame(90, 30, 60);
        run_frame(8'd90, 8'd30, 8'd60, 0, 1'b0, 0);
        d = first_diff();
        n_checks++;
        if (d !== -1) begin
            n_fail++;
            $display("FAIL midreset_stream diverges at %0d got %0d pixels want %0d", d, obs.size(), exp_q.size());
        end
    endtask

    initial begin
        test_reset();
        test_first_frame();
        test_prev_update();
        test_clip();
        test_stall();
        test_busy_ignore();
        test_random();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/frame_renderer.md
Name: frame_renderer

Overview:
- Consumer of the game datapath's object state. Turns bird_y, wall_x and gap_y snapshots into a stream of pixel writes for the VGA adapter.
- Each frame: erase the previous bird and wall in background colour, draw the wall (gap skipped), then draw the bird.
- Sits between the game datapath/controller and the VGA adapter. The controller pulses start once per game tick and waits for done.

Parameters:
- SCREEN_W, 160, visible columns
- SCREEN_H, 120, visible rows
- BIRD_X, 20, fixed bird column (left edge)
- BIRD_SIZE, 4, bird square side in pixels
- WALL_WIDTH, 10, wall thickness in columns
- GAP_H, 40, vertical gap height in rows

Ports:
- clk  in  1  system clock
- resetn  in  1  asynchronous active-low reset
- start  in  1  one-cycle request to render a frame
- bird_y  in  8  bird top row
- wall_x  in  8  wall left column
- gap_y  in  8  gap top row
- pix_ready  in  1  VGA side accepts the current pixel
- x_out  out  8  pixel column
- y_out  out  7  pixel row
- colour_out  out  3  pixel colour
- plot  out  1  pixel valid
- busy  out  1  frame in progress
- done  out  1  one-cycle pulse after the final pixel of a frame

Behaviour:
- Reset (async, resetn=0):
  - state=IDLE; plot=0, busy=0, done=0; x_out=0, y_out=0, colour_out=0.
  - prev_bird_y=60, prev_wall_x=100.
  - Reset mid-frame abandons the frame and emits no further plots.
- IDLE:
  - start=1 latches bird_y, wall_x, gap_y into cur_* registers, sets busy=1 and moves to CLR_BIRD on the next edge.
  - start while busy is ignored; no queueing.
- State order: CLR_BIRD -> CLR_WALL -> DRW_WALL -> DRW_BIRD -> DONE -> IDLE.
- Rectangles scanned per state, raster order (x inner, y outer), starting at top-left:
  - CLR_BIRD: x BIRD_X..+BIRD_SIZE-1, y prev_bird_y..+BIRD_SIZE-1, colour 3'b111.
  - CLR_WALL: x prev_wall_x..+WALL_WIDTH-1, y 0..SCREEN_H-1, colour 3'b111.
  - DRW_WALL: x cur_wall_x..+WALL_WIDTH-1, y 0..SCREEN_H-1, colour 3'b100. Rows in cur_gap_y..cur_gap_y+GAP_H-1 are skipped.
  - DRW_BIRD: x BIRD_X.., y cur_bird_y.., colour 3'b010.
- Pixel handshake and timing:
  - A scan position is emittable when x<SCREEN_W, y<SCREEN_H and it is not a gap row.
  - Emittable: plot=1 with x_out/y_out/colour_out valid. The position advances only on a cycle with plot&&pix_ready. Outputs are held stable while pix_ready=0.
  - Non-emittable (clipped or gap): plot=0 and the position advances in exactly one cycle.
  - No idle cycles between rectangles. The first scan position is presented the cycle after start is accepted.
- Bounds arithmetic is 9 bits wide, so x+WALL_WIDTH overflow past 255 never wraps into visible columns.
- DONE: done=1 for one cycle. prev_bird_y<=cur_bird_y, prev_wall_x<=cur_wall_x. busy drops when returning to IDLE.
- Input changes while busy have no effect; the snapshot is used.

Decomposition:
- Shared package holds:
  - colour constants BIRD_COLOUR=3'b010, WALL_COLOUR=3'b100, BACKGROUND_COLOUR=3'b111
  - start positions BIRD_Y_START=60, WALL_X_START=100
  - screen size
  - the renderer state encoding
- One natural sub-module, rect_scanner:
  - inputs: origin, width, height, advance
  - outputs: current x/y, last flag, in-bounds flag
  - reloaded per state; the FSM adds colour and gap masking.

Test Plan:
- Reset, start with bird_y=60, wall_x=100, gap_y=40, pix_ready=1 -> 16 plots colour 111 at x20-23/y60-63; then 1200 plots of 111; then 800 plots of 100 with no y in 40-79; then 16 plots of 010; done exactly 2433 cycles after the start cycle.
- Second frame with bird_y=50, wall_x=96 -> CLR_BIRD targets y60-63 and CLR_WALL x100-109, proving prev registers updated.
- wall_x=155 -> DRW_WALL emits only x155-159, 5*80=400 plots; no x>=160 ever; bird_y=118 -> DRW_BIRD emits 8 plots (rows 118,119).
- pix_ready toggled 1-0-0-1 during DRW_BIRD -> x_out/y_out/colour_out and plot held through stall; no pixel duplicated or dropped; total plot&&pix_ready count still 16.
- start pulsed again while busy -> ignored, exactly one done; inputs changed mid-frame -> emitted coordinates follow the snapshot.
- resetn low during CLR_WALL -> plot=0, busy=0 immediately (async); next frame clears at y60/x100 start positions.
